// File: rtl/arithmetic_pkg.sv
// Shared arithmetic definitions for the NTM behavioural math models.
// Holds the vector-tanh state encoding and the real constants used by the
// optional saturation path (NTM_TANH_SATURATION_EN).
package arithmetic_pkg;

   localparam logic [63:0] ZERO_DATA = '0;

   typedef enum logic [1:0] {
      STARTER_STATE,
      INPUT_STATE,
      ENDER_STATE
   } tanh_vector_state_t;

   localparam real TANH_SATURATION_LIMIT = 20.0;
   localparam real ONE_REAL              = 1.0;

endpackage

// File: rtl/model_tanh_real_core.sv
// Combinational real tanh: IEEE-754 double bits in, tanh bits and overflow out.
// Build option NTM_TANH_SATURATION_EN: clamp |x| >= TANH_SATURATION_LIMIT to
// exactly +/-1.0 and flag saturation, infinities and NaN on overflow_o.
module model_tanh_real_core
   import arithmetic_pkg::*;
(
   input  logic [63:0] x_bits_i,
   output logic [63:0] y_bits_o,
   output logic        overflow_o
);

   real x_r;

   // Evaluate tanh for the held operand, with optional saturation handling
   always_comb begin
      x_r        = $bitstoreal(x_bits_i);
      y_bits_o   = $realtobits($tanh(x_r));
      overflow_o = 1'b0;
`ifdef NTM_TANH_SATURATION_EN
      if (x_r != x_r) begin
         // NaN: forward the original pattern so the payload survives
         y_bits_o   = x_bits_i;
         overflow_o = 1'b1;
      end else if (x_r >= TANH_SATURATION_LIMIT) begin
         y_bits_o   = $realtobits(ONE_REAL);
         overflow_o = 1'b1;
      end else if (x_r <= -TANH_SATURATION_LIMIT) begin
         y_bits_o   = $realtobits(-ONE_REAL);
         overflow_o = 1'b1;
      end
`endif
   end

endmodule

// File: rtl/model_vector_tanh_function.sv
// Behavioural vector tanh: streams SIZE_IN double elements through one
// model_tanh_real_core with a per-element request/valid handshake.
// READY pulses with the final DATA_OUT_ENABLE (or one cycle after START when
// SIZE_IN is zero). Optional macro: NTM_TANH_SATURATION_EN (see core).
module model_vector_tanh_function
   import arithmetic_pkg::*;
#(
   parameter int DATA_SIZE    = 64,
   parameter int CONTROL_SIZE = 4,
   parameter int INDEX_SIZE   = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  START,
   output logic                  READY,
   input  logic [INDEX_SIZE-1:0] SIZE_IN,
   input  logic                  DATA_IN_ENABLE,
   output logic                  DATA_ENABLE,
   input  logic [DATA_SIZE-1:0]  DATA_IN,
   output logic                  DATA_OUT_ENABLE,
   output logic [DATA_SIZE-1:0]  DATA_OUT,
   output logic                  OVERFLOW_OUT
);

   if (DATA_SIZE != 64 || CONTROL_SIZE < 1) begin : g_param_check
      $error("model_vector_tanh_function: DATA_SIZE must be 64 and CONTROL_SIZE >= 1");
   end

   tanh_vector_state_t state_q, state_d;

   logic                  ready_q, ready_d;
   logic                  data_enable_q, data_enable_d;
   logic                  data_out_enable_q, data_out_enable_d;
   logic [DATA_SIZE-1:0]  data_out_q, data_out_d;
   logic                  overflow_q, overflow_d;
   logic [INDEX_SIZE-1:0] index_q, index_d;
   logic [INDEX_SIZE-1:0] size_q, size_d;
   real                   data_int_q, data_int_d;

   logic [63:0] core_x;
   logic [63:0] core_y;
   logic        core_ovf;
   logic        last_elem;

   assign core_x    = $realtobits(data_int_q);
   assign last_elem = (index_q == size_q - INDEX_SIZE'(1));

   model_tanh_real_core u_core (
      .x_bits_i   (core_x),
      .y_bits_o   (core_y),
      .overflow_o (core_ovf)
   );

   // State and registered-output storage with asynchronous reset
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q           <= STARTER_STATE;
         ready_q           <= 1'b0;
         data_enable_q     <= 1'b0;
         data_out_enable_q <= 1'b0;
         data_out_q        <= ZERO_DATA;
         overflow_q        <= 1'b0;
         index_q           <= '0;
         size_q            <= '0;
         data_int_q        <= 0.0;
      end else begin
         state_q           <= state_d;
         ready_q           <= ready_d;
         data_enable_q     <= data_enable_d;
         data_out_enable_q <= data_out_enable_d;
         data_out_q        <= data_out_d;
         overflow_q        <= overflow_d;
         index_q           <= index_d;
         size_q            <= size_d;
         data_int_q        <= data_int_d;
      end
   end

   // Next-state selection
   always_comb begin
      state_d = state_q;
      case (state_q)
         STARTER_STATE: if (START && SIZE_IN != '0) state_d = INPUT_STATE;
         INPUT_STATE:   if (DATA_IN_ENABLE) state_d = ENDER_STATE;
         ENDER_STATE:   state_d = last_elem ? STARTER_STATE : INPUT_STATE;
         default:       state_d = STARTER_STATE;
      endcase
   end

   // Next values for pulses, result hold registers and element bookkeeping
   always_comb begin
      ready_d           = 1'b0;
      data_enable_d     = 1'b0;
      data_out_enable_d = 1'b0;
      data_out_d        = data_out_q;
      overflow_d        = overflow_q;
      index_d           = index_q;
      size_d            = size_q;
      data_int_d        = data_int_q;
      case (state_q)
         STARTER_STATE: begin
            if (START) begin
               size_d  = SIZE_IN;
               index_d = '0;
               if (SIZE_IN == '0) ready_d = 1'b1;
               else               data_enable_d = 1'b1;
            end
         end
         INPUT_STATE: begin
            if (DATA_IN_ENABLE) data_int_d = $bitstoreal(DATA_IN);
         end
         ENDER_STATE: begin
            data_out_d        = core_y;
            overflow_d        = core_ovf;
            data_out_enable_d = 1'b1;
            if (last_elem) begin
               ready_d = 1'b1;
            end else begin
               index_d       = index_q + INDEX_SIZE'(1);
               data_enable_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign READY           = ready_q;
   assign DATA_ENABLE     = data_enable_q;
   assign DATA_OUT_ENABLE = data_out_enable_q;
   assign DATA_OUT        = data_out_q;
   assign OVERFLOW_OUT    = overflow_q;

endmodule
